data_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 256 x 8 data memory. It shares the memory's single address/read/write port between two requesters: port 0 is the core load/store unit, port 1 is a debug/DMA loader. Each cycle it accepts at most one request, registers the command, and drives the memory for exactly one cycle. It captures the memory's combinational read data and returns it to the owning requester with a valid pulse.

---
 rtl/data_mem_arbiter.sv | 74 +++++++
 tb/tb_data_mem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one 256x8 data memory port between the load/store unit (port 0) and a debug/DMA loader (port 1).
// Accepts at most one request per cycle; the registered command drives the memory for exactly one cycle.
module data_mem_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  logic          cmd_valid, cmd_port, cmd_we, last_port;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          any_req, tie, win1, rd_done;
  always_comb begin
    any_req = req0 | req1;
    tie     = req0 & req1;
    // on a round-robin tie the port that did not win the previous tie goes first
    win1    = req1 & (!req0 | (FIXED_PRIO == 0 && !last_port));
    rd_done = cmd_valid & !cmd_we;
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd_port  <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      last_port <= 1'b1;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      cmd_valid <= any_req;
      if (any_req) begin
        cmd_port  <= win1;
        cmd_we    <= win1 ? we1 : we0;
        cmd_addr  <= win1 ? addr1 : addr0;
        cmd_wdata <= win1 ? wdata1 : wdata0;
      end
      if (tie && FIXED_PRIO == 0) last_port <= win1;
      rvalid0 <= rd_done & !cmd_port;
      rvalid1 <= rd_done & cmd_port;
      if (rd_done && !cmd_port) rdata0 <= mem_rdata;
      if (rd_done && cmd_port) rdata1 <= mem_rdata;
    end
  end
  assign gnt0      = cmd_valid & !cmd_port;
  assign gnt1      = cmd_valid & cmd_port;
  assign mem_read  = cmd_valid & !cmd_we;
  assign mem_write = cmd_valid & cmd_we;
  assign mem_addr  = cmd_valid ? cmd_addr : '0;
  assign mem_wdata = cmd_valid ? cmd_wdata : '0;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: drives a round-robin and a fixed-priority arbiter with shared stimulus and
// scores every cycle against a behavioural reference model of arbiter plus memory.
module tb_data_mem_arbiter;
  typedef struct packed {
    logic       g0, g1, v0, v1, rd, wr;
    logic [7:0] a, wd, r0, r1;
  } obs_t;

  logic       CLK = 1'b0, reset = 1'b1;
  logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic       ga0, ga1, va0, va1, rda, wra, gb0, gb1, vb0, vb1, rdb, wrb;
  logic [7:0] ra0, ra1, aa, wda, rma, rb0, rb1, ab, wdb, rmb;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic       init_done = 1'b0;
  obs_t       obs_a, obs_b, exp_e;
  obs_t       qa[$], qb[$];
  int         errors = 0, checks = 0;

  logic       mv[2], mp[2], mw[2], ml[2], mv0[2], mv1[2];
  logic [7:0] ma[2], md[2], mr0[2], mr1[2];
  logic [7:0] mm[2][256];

  always #5 CLK = ~CLK;

  data_mem_arbiter #(.FIXED_PRIO(0), .AW(8), .DW(8)) dut_a (
    .CLK(CLK), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(ga0), .gnt1(ga1), .rvalid0(va0), .rvalid1(va1), .rdata0(ra0), .rdata1(ra1),
    .mem_addr(aa), .mem_read(rda), .mem_write(wra), .mem_wdata(wda), .mem_rdata(rma));

  data_mem_arbiter #(.FIXED_PRIO(1), .AW(8), .DW(8)) dut_b (
    .CLK(CLK), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gb0), .gnt1(gb1), .rvalid0(vb0), .rvalid1(vb1), .rdata0(rb0), .rdata1(rb1),
    .mem_addr(ab), .mem_read(rdb), .mem_write(wrb), .mem_wdata(wdb), .mem_rdata(rmb));

  function automatic logic [7:0] init_val(input int i);
    logic [7:0] v;
    v = 8'(i);
    return (i < 4) ? 8'h20 + v : v ^ 8'h5A;
  endfunction

  // memories: contents loaded on the first edge, writes ignored while reset is high
  always @(posedge CLK) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= init_val(i);
        mem_b[i] <= init_val(i);
      end
      init_done <= 1'b1;
    end else if (!reset) begin
      if (wra) mem_a[aa] <= wda;
      if (wrb) mem_b[ab] <= wdb;
    end
  end
  assign rma   = rda ? mem_a[aa] : 8'h00;
  assign rmb   = rdb ? mem_b[ab] : 8'h00;
  assign obs_a = {ga0, ga1, va0, va1, rda, wra, aa, wda, ra0, ra1};
  assign obs_b = {gb0, gb1, vb0, vb1, rdb, wrb, ab, wdb, rb0, rb1};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // reference: state the arbiter should hold after the coming edge, given the current inputs
  task automatic step(input int k, input bit fp, output obs_t e);
    logic w;
    if (reset) begin
      mv[k] = 0; mp[k] = 0; mw[k] = 0; ma[k] = 0; md[k] = 0; ml[k] = 1;
      mr0[k] = 0; mr1[k] = 0; mv0[k] = 0; mv1[k] = 0;
    end else begin
      mv0[k] = mv[k] && !mw[k] && !mp[k];
      mv1[k] = mv[k] && !mw[k] && mp[k];
      if (mv0[k]) mr0[k] = mm[k][ma[k]];
      if (mv1[k]) mr1[k] = mm[k][ma[k]];
      if (mv[k] && mw[k]) mm[k][ma[k]] = md[k];
      if (req0 && req1) begin
        w = fp ? 1'b0 : !ml[k];
        if (!fp) ml[k] = w;
      end else w = req1;
      mv[k] = req0 | req1;
      if (mv[k]) begin
        mp[k] = w;
        mw[k] = w ? we1 : we0;
        ma[k] = w ? addr1 : addr0;
        md[k] = w ? wdata1 : wdata0;
      end
    end
    e.g0 = mv[k] && !mp[k];
    e.g1 = mv[k] && mp[k];
    e.v0 = mv0[k];
    e.v1 = mv1[k];
    e.rd = mv[k] && !mw[k];
    e.wr = mv[k] && mw[k];
    e.a  = mv[k] ? ma[k] : 8'h00;
    e.wd = mv[k] ? md[k] : 8'h00;
    e.r0 = mr0[k];
    e.r1 = mr1[k];
  endtask

  task automatic cyc(input string tag);
    step(0, 1'b0, exp_e);
    qa.push_back(exp_e);
    step(1, 1'b1, exp_e);
    qb.push_back(exp_e);
    @(posedge CLK);
    #1;
    check({tag, " rr"}, 64'(obs_a), 64'(qa.pop_front()));
    check({tag, " fp"}, 64'(obs_b), 64'(qb.pop_front()));
  endtask

  initial begin
    logic [7:0] exp_v;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) mm[k][i] = init_val(i);
    cyc("reset");
    cyc("reset");
    reset = 0;
    cyc("idle");
    // write 0xA5 to 0x10 then read it back
    req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'hA5;
    cyc("wr0");
    we0 = 0;
    cyc("rd0");
    req0 = 0;
    cyc("rd0 data");
    check("rd0 rdata0", 64'(ra0), 64'h A5);
    check("rd0 rvalid0", 64'(va0), 64'h1);
    cyc("idle");
    // both ports busy: port 0 writes 0x11.., port 1 reads
    req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 8'h11;
    req1 = 1; we1 = 0; addr1 = 8'h10;
    for (int i = 0; i < 4; i++) begin
      cyc("tie");
      check("tie gnt excl", 64'(ga0 & ga1), 64'h0);
      if (ga0) begin wdata0 = wdata0 + 1; addr0 = addr0 + 1; end
    end
    req0 = 0; req1 = 0;
    cyc("tie drain");
    cyc("tie drain");
    // priority hold then release of port 0
    req0 = 1; we0 = 0; addr0 = 8'h31; req1 = 1; addr1 = 8'h30;
    for (int i = 0; i < 5; i++) cyc("prio");
    req0 = 0;
    cyc("prio drop");
    check("prio gnt1", 64'(gb1), 64'h1);
    req1 = 0;
    cyc("prio drain");
    cyc("prio drain");
    // port 1 streams four reads
    for (int i = 0; i < 5; i++) begin
      req1 = (i < 4);
      addr1 = 8'(i);
      cyc("stream");
      if (i > 0) begin
        exp_v = 8'h20 + 8'(i - 1);
        check("stream rdata1", 64'(ra1), 64'(exp_v));
        check("stream gnt1", 64'(ga1), 64'(i < 4));
      end
    end
    cyc("idle");
    // write interrupted by reset
    req0 = 1; we0 = 1; addr0 = 8'h05; wdata0 = 8'h77;
    cyc("rst wr");
    req0 = 0;
    reset = 1;
    cyc("rst edge");
    reset = 0;
    check("rst mem5", 64'(mem_a[5]), 64'(init_val(5)));
    req0 = 1; we0 = 0; addr0 = 8'h05; req1 = 1; we1 = 0; addr1 = 8'h06;
    cyc("post rst tie");
    check("post rst gnt0", 64'(ga0), 64'h1);
    req0 = 0;
    cyc("post rst");
    check("post rst rdata0", 64'(ra0), 64'(init_val(5)));
    req1 = 0;
    for (int i = 0; i < 4; i++) cyc("idle hold");
    check("idle hold rdata1", 64'(ra1), 64'(init_val(6)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
